// File: rtl/cpu_pkg.sv
// Shared definitions for the pipelined CPU: ALUOp/funct encodings, ALU operation
// and multiplier state types, plus small decode and forwarding helpers.
package cpu_pkg;

    localparam int XLEN  = 32;
    localparam int REG_W = 5;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_ADDI  = 2'b11;

    localparam logic [5:0] FUNCT_ADD = 6'h20;
    localparam logic [5:0] FUNCT_SUB = 6'h22;
    localparam logic [5:0] FUNCT_AND = 6'h24;
    localparam logic [5:0] FUNCT_OR  = 6'h25;
    localparam logic [5:0] FUNCT_SLT = 6'h2A;
    localparam logic [5:0] FUNCT_MUL = 6'h18;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_SLT,
        ALU_MUL
    } alu_ctl_e;

    typedef enum logic [1:0] {
        MUL_IDLE,
        MUL_BUSY,
        MUL_DONE
    } mul_state_e;

    // Unknown funct codes fall back to add so a bad encoding never wedges the pipe.
    function automatic alu_ctl_e decodeAlu(input logic [1:0] aluOp, input logic [5:0] funct);
        alu_ctl_e ctl;
        ctl = ALU_ADD;
        case (aluOp)
            ALUOP_SUB: ctl = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    FUNCT_SUB: ctl = ALU_SUB;
                    FUNCT_AND: ctl = ALU_AND;
                    FUNCT_OR:  ctl = ALU_OR;
                    FUNCT_SLT: ctl = ALU_SLT;
                    FUNCT_MUL: ctl = ALU_MUL;
                    default:   ctl = ALU_ADD;
                endcase
            end
            default: ctl = ALU_ADD;
        endcase
        return ctl;
    endfunction

    function automatic logic [XLEN-1:0] selectForward(
        input logic [REG_W-1:0] idx,
        input logic             exmemOk,
        input logic [REG_W-1:0] exmemDest,
        input logic [XLEN-1:0]  exmemData,
        input logic             memwbWrite,
        input logic [REG_W-1:0] memwbRd,
        input logic [XLEN-1:0]  memwbData,
        input logic [XLEN-1:0]  rfData
    );
        logic [XLEN-1:0] value;
        value = rfData;
        if (exmemOk && exmemDest == idx) begin
            value = exmemData;
        end else if (memwbWrite && memwbRd != '0 && memwbRd == idx) begin
            value = memwbData;
        end
        return value;
    endfunction

endpackage

// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier: one partial product per cycle over 32 cycles,
// low 32 bits of the product held in DONE for exactly one cycle.
module seq_multiplier
    import cpu_pkg::*;
(
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] product_o
);

    mul_state_e      state_q;
    logic [XLEN-1:0] multiplicand_q;
    logic [XLEN-1:0] multiplier_q;
    logic [XLEN-1:0] accum_q;
    logic [4:0]      count_q;
    logic            busy_q;
    logic            done_q;

    // Multiplicand shifts left and multiplier right so each step only inspects bit 0.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q        <= MUL_IDLE;
            multiplicand_q <= '0;
            multiplier_q   <= '0;
            accum_q        <= '0;
            count_q        <= '0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            case (state_q)
                MUL_IDLE: begin
                    if (start_i) begin
                        state_q        <= MUL_BUSY;
                        multiplicand_q <= a_i;
                        multiplier_q   <= b_i;
                        accum_q        <= '0;
                        count_q        <= '0;
                        busy_q         <= 1'b1;
                    end
                end
                MUL_BUSY: begin
                    if (multiplier_q[0]) begin
                        accum_q <= accum_q + multiplicand_q;
                    end
                    multiplicand_q <= multiplicand_q << 1;
                    multiplier_q   <= multiplier_q >> 1;
                    count_q        <= count_q + 5'd1;
                    if (count_q == 5'd31) begin
                        state_q <= MUL_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                MUL_DONE: begin
                    state_q <= MUL_IDLE;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= MUL_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign product_o = accum_q;

endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, ALU control and ALU, the iterative multiplier
// and the EX/MEM pipeline register feeding the memory stage.
module ex_stage
    import cpu_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    input  logic [1:0]       wb_i,
    input  logic [1:0]       m_i,
    input  logic             reg_dst_i,
    input  logic [1:0]       alu_op_i,
    input  logic             alu_src_i,
    input  logic [XLEN-1:0]  rs_data_i,
    input  logic [XLEN-1:0]  rt_data_i,
    input  logic [XLEN-1:0]  imm_i,
    input  logic [REG_W-1:0] rs_i,
    input  logic [REG_W-1:0] rt_i,
    input  logic [REG_W-1:0] rd_i,
    input  logic             memwb_reg_write_i,
    input  logic [REG_W-1:0] memwb_rd_i,
    input  logic [XLEN-1:0]  memwb_data_i,
    output logic             stall_o,
    output logic             valid_o,
    output logic [1:0]       wb_o,
    output logic [1:0]       m_o,
    output logic [XLEN-1:0]  alu_result_o,
    output logic [XLEN-1:0]  store_data_o,
    output logic [REG_W-1:0] dest_o
);

    alu_ctl_e         aluCtl;
    logic             isMul;
    logic             mulStart;
    logic             mulBusy;
    logic             mulDone;
    logic [XLEN-1:0]  product;
    logic             exmemFwdOk;
    logic [XLEN-1:0]  opA;
    logic [XLEN-1:0]  rtFwd;
    logic [XLEN-1:0]  opB;
    logic [XLEN-1:0]  aluResult;

    logic             valid_q;
    logic [1:0]       wb_q;
    logic [1:0]       m_q;
    logic [XLEN-1:0]  result_q;
    logic [XLEN-1:0]  storeData_q;
    logic [REG_W-1:0] dest_q;

    assign aluCtl = decodeAlu(alu_op_i, imm_i[5:0]);
    assign isMul  = (aluCtl == ALU_MUL);

    // A load in EX/MEM has only an address, so it must not be forwarded.
    assign exmemFwdOk = valid_q && wb_q[1] && !m_q[1] && (dest_q != '0);

    assign opA   = selectForward(rs_i, exmemFwdOk, dest_q, result_q,
                                 memwb_reg_write_i, memwb_rd_i, memwb_data_i, rs_data_i);
    assign rtFwd = selectForward(rt_i, exmemFwdOk, dest_q, result_q,
                                 memwb_reg_write_i, memwb_rd_i, memwb_data_i, rt_data_i);
    assign opB   = alu_src_i ? imm_i : rtFwd;

    always_comb begin
        aluResult = opA + opB;
        case (aluCtl)
            ALU_SUB: aluResult = opA - opB;
            ALU_AND: aluResult = opA & opB;
            ALU_OR:  aluResult = opA | opB;
            ALU_SLT: aluResult = {31'd0, $signed(opA) < $signed(opB)};
            default: aluResult = opA + opB;
        endcase
    end

    assign mulStart = valid_i && isMul && !mulBusy && !mulDone;
    assign stall_o  = !rst_i && valid_i && isMul && !mulDone;

    seq_multiplier u_mul (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .start_i   (mulStart),
        .a_i       (opA),
        .b_i       (opB),
        .busy_o    (mulBusy),
        .done_o    (mulDone),
        .product_o (product)
    );

    // While stalled the mul stays in ID/EX, so EX/MEM receives bubbles until DONE.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q     <= 1'b0;
            wb_q        <= '0;
            m_q         <= '0;
            result_q    <= '0;
            storeData_q <= '0;
            dest_q      <= '0;
        end else if (stall_o) begin
            valid_q <= 1'b0;
            wb_q    <= '0;
            m_q     <= '0;
        end else begin
            valid_q     <= valid_i;
            wb_q        <= valid_i ? wb_i : 2'b00;
            m_q         <= valid_i ? m_i : 2'b00;
            result_q    <= mulDone ? product : aluResult;
            storeData_q <= rtFwd;
            dest_q      <= reg_dst_i ? rd_i : rt_i;
        end
    end

    assign valid_o      = valid_q;
    assign wb_o         = wb_q;
    assign m_o          = m_q;
    assign alu_result_o = result_q;
    assign store_data_o = storeData_q;
    assign dest_o       = dest_q;

endmodule
